// File: rtl/cond_pkg.sv
// Shared types and constants for the execute-stage condition unit.
package cond_pkg;

  // ARM condition field encodings
  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_t;

  // Bit positions inside a {N,Z,C,V} flag nibble
  localparam int unsigned N_IDX = 3;
  localparam int unsigned Z_IDX = 2;
  localparam int unsigned C_IDX = 1;
  localparam int unsigned V_IDX = 0;

  // IT-block sequencer states
  typedef enum logic {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_t;

  // Each condition pair differs only in the LSB; flipping it gives the opposite sense
  function automatic logic [3:0] cond_invert(input logic [3:0] c);
    return c ^ 4'b0001;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator: {cond, flags} -> pass.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  // Decode the condition field against the supplied flags; NV is a defined never-pass
  always_comb begin
    n    = flags[N_IDX];
    z    = flags[Z_IDX];
    c    = flags[C_IDX];
    v    = flags[V_IDX];
    pass = 1'b0;
    case (cond_t'(cond))
      EQ:      pass = z;
      NE:      pass = ~z;
      CS:      pass = c;
      CC:      pass = ~c;
      MI:      pass = n;
      PL:      pass = ~n;
      VS:      pass = v;
      VC:      pass = ~v;
      HI:      pass = c & ~z;
      LS:      pass = ~(c & ~z);
      GE:      pass = (n == v);
      LT:      pass = (n != v);
      GT:      pass = ~z & (n == v);
      LE:      pass = ~(~z & (n == v));
      AL:      pass = 1'b1;
      NV:      pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Execute-stage condition unit: per-context NZCV banks, IT-block predication,
// and gating of RegWrite/MemWrite/PCSrc before they enter the M stage.
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter  int unsigned NUM_CTX = 1,
  parameter  int unsigned IT_MAX  = 4,
  localparam int unsigned CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  localparam int unsigned LEN_W   = $clog2(IT_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ValidE,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic [CTX_W-1:0]  CtxE,
  input  logic [3:0]        CondE,
  input  logic [1:0]        FlagWriteE,
  input  logic [3:0]        ALUFlagsE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              PCSrcE,
  input  logic              ITStartE,
  input  logic [LEN_W-1:0]  ITLenE,
  input  logic [IT_MAX-1:0] ITMaskE,
  output logic              CondExE,
  output logic              RegWriteGE,
  output logic              MemWriteGE,
  output logic              PCSrcGE,
  output logic [3:0]        FlagsE,
  output logic              ITActive,
  output logic              ITErr
);

  logic [3:0]        bank_q [NUM_CTX];
  it_state_t         it_state_q;
  logic [3:0]        it_base_q;
  logic [IT_MAX-1:0] it_mask_q;
  logic [CTX_W-1:0]  it_ctx_q;
  logic [LEN_W-1:0]  it_left_q;
  logic              it_err_q;

  logic [CTX_W-1:0]  ctx_idx;
  logic [3:0]        cur_flags;
  logic [3:0]        eff_cond;
  logic              in_it;
  logic              advance;
  logic              len_ok;
  logic              cond_pass;
  logic              gate;

  // Context select (out-of-range contexts fold onto bank 0) and bank read-out
  always_comb begin
    ctx_idx   = ({1'b0, CtxE} < (CTX_W + 1)'(NUM_CTX)) ? CtxE : '0;
    cur_flags = '0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (CTX_W'(i) == ctx_idx) cur_flags = bank_q[i];
    end
  end

  // Effective condition: IT slots of the owning context override CondE
  always_comb begin
    advance  = ValidE & ~StallE & ~FlushE;
    in_it    = (it_state_q == IT_ACTIVE) && (ctx_idx == it_ctx_q);
    eff_cond = in_it ? (it_mask_q[0] ? it_base_q : cond_invert(it_base_q)) : CondE;
    len_ok   = (ITLenE != '0) && (ITLenE <= LEN_W'(IT_MAX));
  end

  cond_eval u_cond_eval (
    .cond  (eff_cond),
    .flags (cur_flags),
    .pass  (cond_pass)
  );

  // Gated control outputs
  always_comb begin
    gate       = cond_pass & ValidE & ~FlushE;
    CondExE    = cond_pass;
    RegWriteGE = RegWriteE & gate;
    MemWriteGE = MemWriteE & gate;
    PCSrcGE    = PCSrcE & gate;
    FlagsE     = cur_flags;
    ITActive   = (it_state_q == IT_ACTIVE);
    ITErr      = it_err_q;
  end

  // Flag banks: partial NZ / CV writes, only the selected context, only when executed
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CTX; i++) bank_q[i] <= '0;
    end else if (advance && cond_pass) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (CTX_W'(i) == ctx_idx) begin
          if (FlagWriteE[1]) bank_q[i][N_IDX:Z_IDX] <= ALUFlagsE[N_IDX:Z_IDX];
          if (FlagWriteE[0]) bank_q[i][C_IDX:V_IDX] <= ALUFlagsE[C_IDX:V_IDX];
        end
      end
    end
  end

  // IT sequencer: mask is shifted so bit 0 always belongs to the current slot
  always_ff @(posedge clk) begin
    if (reset) begin
      it_state_q <= IT_IDLE;
      it_base_q  <= '0;
      it_mask_q  <= '0;
      it_ctx_q   <= '0;
      it_left_q  <= '0;
      it_err_q   <= 1'b0;
    end else begin
      it_err_q <= advance && in_it && ITStartE;
      if (FlushE) begin
        it_state_q <= IT_IDLE;
        it_left_q  <= '0;
      end else if (advance) begin
        case (it_state_q)
          IT_IDLE: begin
            if (ITStartE && cond_pass && len_ok) begin
              it_state_q <= IT_ACTIVE;
              it_base_q  <= CondE;
              it_mask_q  <= ITMaskE;
              it_ctx_q   <= ctx_idx;
              it_left_q  <= ITLenE;
            end
          end
          IT_ACTIVE: begin
            if (in_it) begin
              it_mask_q <= it_mask_q >> 1;
              it_left_q <= it_left_q - LEN_W'(1);
              if (it_left_q == LEN_W'(1)) it_state_q <= IT_IDLE;
            end
          end
          default: it_state_q <= IT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Self-checking bench for cond_exec_unit (NUM_CTX=3, IT_MAX=4): directed table
// with hand-derived expectations plus randomized traffic against a queue-based model.
module tb_cond_exec_unit;

  localparam int unsigned NCTX = 3;

  typedef struct {
    logic       valid, stall, flush;
    logic [1:0] ctx;
    logic [3:0] cond;
    logic [1:0] fw;
    logic [3:0] alu;
    logic       rw, mw, pc;
    logic       its;
    logic [2:0] len;
    logic [3:0] mask;
    logic       ecx, eact, eerr;
    logic [3:0] eflags;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ValidE, StallE, FlushE;
  logic [1:0] CtxE;
  logic [3:0] CondE;
  logic [1:0] FlagWriteE;
  logic [3:0] ALUFlagsE;
  logic       RegWriteE, MemWriteE, PCSrcE;
  logic       ITStartE;
  logic [2:0] ITLenE;
  logic [3:0] ITMaskE;
  logic       CondExE, RegWriteGE, MemWriteGE, PCSrcGE;
  logic [3:0] FlagsE;
  logic       ITActive, ITErr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [3:0] m_bank [NCTX];
  logic [3:0] m_q [$];
  int         m_ctx;
  bit         m_err;
  int         m_idx;
  bit         m_in_it;
  bit         m_pass;

  cond_exec_unit #(.NUM_CTX(3), .IT_MAX(4)) dut (
    .clk(clk), .reset(reset), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
    .CtxE(CtxE), .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlagsE(ALUFlagsE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
    .ITStartE(ITStartE), .ITLenE(ITLenE), .ITMaskE(ITMaskE),
    .CondExE(CondExE), .RegWriteGE(RegWriteGE), .MemWriteGE(MemWriteGE), .PCSrcGE(PCSrcGE),
    .FlagsE(FlagsE), .ITActive(ITActive), .ITErr(ITErr)
  );

  always #5 clk = ~clk;

  // Condition rules grouped by base predicate; odd encodings are the negation
  function automatic bit m_eval(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    r = 1'b0;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? !r : r;
  endfunction

  function automatic vec_t mk(input logic v, input logic st, input logic fl, input logic [1:0] cx,
                              input logic [3:0] cd, input logic [1:0] fw, input logic [3:0] alu,
                              input logic its, input logic [2:0] len, input logic [3:0] mask,
                              input logic ecx, input logic [3:0] eflags, input logic eact,
                              input logic eerr);
    vec_t r;
    r.valid = v; r.stall = st; r.flush = fl; r.ctx = cx; r.cond = cd; r.fw = fw; r.alu = alu;
    r.rw = 1'b1; r.mw = 1'b0; r.pc = 1'b1;
    r.its = its; r.len = len; r.mask = mask;
    r.ecx = ecx; r.eflags = eflags; r.eact = eact; r.eerr = eerr;
    return r;
  endfunction

  task automatic drive(input vec_t s);
    ValidE = s.valid; StallE = s.stall; FlushE = s.flush; CtxE = s.ctx; CondE = s.cond;
    FlagWriteE = s.fw; ALUFlagsE = s.alu; RegWriteE = s.rw; MemWriteE = s.mw; PCSrcE = s.pc;
    ITStartE = s.its; ITLenE = s.len; ITMaskE = s.mask;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCTX; i++) m_bank[i] = 4'b0000;
    m_q.delete();
    m_ctx = 0;
    m_err = 1'b0;
  endtask

  task automatic model_update(input vec_t s);
    bit adv;
    adv   = s.valid && !s.stall && !s.flush;
    m_err = adv && m_in_it && s.its;
    if (adv && m_pass) begin
      if (s.fw[1]) m_bank[m_idx][3:2] = s.alu[3:2];
      if (s.fw[0]) m_bank[m_idx][1:0] = s.alu[1:0];
    end
    if (s.flush) begin
      m_q.delete();
    end else if (adv) begin
      if (m_q.size() == 0) begin
        if (s.its && m_pass && s.len >= 3'd1 && s.len <= 3'd4) begin
          for (int k = 0; k < int'(s.len); k++) m_q.push_back(s.mask[k] ? s.cond : (s.cond ^ 4'b0001));
          m_ctx = m_idx;
        end
      end else if (m_in_it) begin
        void'(m_q.pop_front());
      end
    end
  endtask

  // Drive at negedge, compare mid-cycle, let the DUT and model advance on posedge
  task automatic apply(input vec_t s, input bit use_tbl, input string tag, input int idx);
    logic [9:0] got, exp;
    logic [3:0] eff;
    bit g;
    drive(s);
    #1;
    m_idx   = (s.ctx < 2'd3) ? int'(s.ctx) : 0;
    m_in_it = (m_q.size() > 0) && (m_idx == m_ctx);
    eff     = m_in_it ? m_q[0] : s.cond;
    m_pass  = m_eval(eff, m_bank[m_idx]);
    g       = m_pass && s.valid && !s.flush;
    exp = {m_pass, g & s.rw, g & s.mw, g & s.pc, m_q.size() > 0, m_err, m_bank[m_idx]};
    got = {CondExE, RegWriteGE, MemWriteGE, PCSrcGE, ITActive, ITErr, FlagsE};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s_model step %0d: got %b expected %b", tag, idx, got, exp);
    end
    if (use_tbl) begin
      n_tests++;
      if ({CondExE, ITActive, ITErr, FlagsE} !== {s.ecx, s.eact, s.eerr, s.eflags}) begin
        n_fail++;
        $display("FAIL %s_table row %0d: got cx/act/err/flags %b%b%b_%b expected %b%b%b_%b",
                 tag, idx, CondExE, ITActive, ITErr, FlagsE, s.ecx, s.eact, s.eerr, s.eflags);
      end
    end
    @(posedge clk);
    model_update(s);
    @(negedge clk);
  endtask

  task automatic do_reset();
    vec_t idle;
    idle = mk(0, 0, 0, 2'd0, 4'd0, 2'd0, 4'd0, 0, 3'd0, 4'd0, 0, 4'd0, 0, 0);
    drive(idle);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t tbl [$];

  initial begin
    //               v st fl ctx   cond     fw     alu      its len   mask     ecx flags   act err
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b0000, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1110, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1111, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1110, 2'b11, 4'b0100, 0, 3'd0, 4'b0000, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b0000, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd1, 4'b1110, 2'b10, 4'b1111, 0, 3'd0, 4'b0000, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd1, 4'b0000, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b1100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd1, 4'b0001, 2'b11, 4'b0011, 0, 3'd0, 4'b0000, 0, 4'b1100, 0, 0));
    tbl.push_back(mk(1, 1, 0, 2'd1, 4'b1110, 2'b11, 4'b0011, 0, 3'd0, 4'b0000, 1, 4'b1100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd1, 4'b1110, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b1100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd2, 4'b0000, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd3, 4'b0000, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd1, 4'b1010, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 0, 4'b1100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd1, 4'b1101, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b1100, 0, 0));
    // IT block on ctx0 (Z=1): EQ opener, len 3, mask 101 -> pass, fail, pass
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b0000, 2'b00, 4'b0000, 1, 3'd3, 4'b0101, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1111, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b0100, 1, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1110, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 0, 4'b0100, 1, 0));
    tbl.push_back(mk(1, 0, 0, 2'd2, 4'b1110, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b0000, 1, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1111, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b0100, 1, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b0001, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 0, 4'b0100, 0, 0));
    // Flush of an AL/NV slot together with a new opener
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1110, 2'b00, 4'b0000, 1, 3'd2, 4'b0000, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(1, 0, 1, 2'd0, 4'b1110, 2'b11, 4'b1111, 1, 3'd2, 4'b1111, 0, 4'b0100, 1, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b0000, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b0100, 0, 0));
    // Opener inside an active block becomes a slot and raises ITErr
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1110, 2'b00, 4'b0000, 1, 3'd1, 4'b0001, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1111, 2'b00, 4'b0000, 1, 3'd2, 4'b0011, 1, 4'b0100, 1, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1110, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b0100, 0, 1));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1110, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b0100, 0, 0));
    // Invalid lengths and a failing opener start nothing
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1110, 2'b00, 4'b0000, 1, 3'd0, 4'b1111, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b0001, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 0, 4'b0100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1110, 2'b00, 4'b0000, 1, 3'd5, 4'b1111, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1110, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b0001, 2'b00, 4'b0000, 1, 3'd2, 4'b1111, 0, 4'b0100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b1110, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b0100, 0, 0));
    // Invalid instruction does not write flags
    tbl.push_back(mk(0, 0, 0, 2'd0, 4'b1110, 2'b11, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b0100, 0, 0));
    tbl.push_back(mk(1, 0, 0, 2'd0, 4'b0000, 2'b00, 4'b0000, 0, 3'd0, 4'b0000, 1, 4'b0100, 0, 0));

    reset = 1'b1;
    model_reset();
    do_reset();

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b1, "dir", i);

    for (int i = 0; i < 3000; i++) begin
      vec_t r;
      r = mk($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
             2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), 4'($urandom),
             $urandom_range(0, 6) == 0, 3'($urandom_range(0, 5)), 4'($urandom),
             0, 4'd0, 0, 0);
      r.rw = 1'($urandom); r.mw = 1'($urandom); r.pc = 1'($urandom);
      if (i == 1500) do_reset();
      apply(r, 1'b0, "rand", i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
